// File: rtl/logic_unit_pkg.sv
// logic_unit_pkg
//   Shared definitions for the registered bitwise logic unit.
//   OP_W      : opcode width
//   OP_AND..  : opcode encodings understood by logic_unit_core
package logic_unit_pkg;

    localparam int OP_W = 3;

    localparam logic [OP_W-1:0] OP_AND  = 3'b000;
    localparam logic [OP_W-1:0] OP_OR   = 3'b001;
    localparam logic [OP_W-1:0] OP_XOR  = 3'b010;
    localparam logic [OP_W-1:0] OP_NAND = 3'b011;
    localparam logic [OP_W-1:0] OP_NOR  = 3'b100;
    localparam logic [OP_W-1:0] OP_XNOR = 3'b101;
    localparam logic [OP_W-1:0] OP_INV  = 3'b110;
    localparam logic [OP_W-1:0] OP_BUF  = 3'b111;

endpackage

// File: rtl/logic_unit_core.sv
// logic_unit_core
//   Purely combinational bitwise operator selected by op.
//   Ports:
//     a      in   WIDTH  operand A
//     b_eff  in   WIDTH  effective operand B (b or accumulator, chosen upstream)
//     op     in   OP_W   opcode
//     r      out  WIDTH  result
module logic_unit_core
    import logic_unit_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b_eff,
    input  logic [OP_W-1:0]  op,
    output logic [WIDTH-1:0] r
);

    always_comb begin
        r = a & b_eff;
        case (op)
            OP_AND:  r = a & b_eff;
            OP_OR:   r = a | b_eff;
            OP_XOR:  r = a ^ b_eff;
            OP_NAND: r = ~(a & b_eff);
            OP_NOR:  r = ~(a | b_eff);
            OP_XNOR: r = ~(a ^ b_eff);
            OP_INV:  r = ~a;
            OP_BUF:  r = a;
            default: r = a & b_eff;
        endcase
    end

endmodule

// File: rtl/logic_unit_pipe.sv
// logic_unit_pipe
//   One-stage registered bitwise logic unit with valid/ready handshake and an
//   accumulate mode that feeds the previous accepted result back as operand B.
//   Ports:
//     clk        in   1      rising-edge clock
//     reset_n    in   1      asynchronous active-low reset
//     in_valid   in   1      operand beat valid
//     in_ready   out  1      beat can be accepted this cycle
//     op         in   3      opcode (AND/OR/XOR/NAND/NOR/XNOR/INV/BUF)
//     acc_sel    in   1      use accumulator instead of b
//     a, b       in   WIDTH  operands
//     out_valid  out  1      result valid
//     out_ready  in   1      consumer accepts result
//     y          out  WIDTH  registered result
//     zero       out  1      registered (y == 0)
//     parity     out  1      registered XOR-reduce of y
module logic_unit_pipe
    import logic_unit_pkg::*;
#(
    parameter int          WIDTH    = 32,
    parameter int unsigned ACC_INIT = 0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [OP_W-1:0]  op,
    input  logic             acc_sel,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] y,
    output logic             zero,
    output logic             parity
);

    localparam logic [WIDTH-1:0] ACC_RST = WIDTH'(ACC_INIT);

    logic [WIDTH-1:0] b_eff_p0;
    logic [WIDTH-1:0] r_p0;
    logic             accept_p0;

    logic [WIDTH-1:0] y_p1;
    logic [WIDTH-1:0] acc_p1;
    logic             zero_p1;
    logic             parity_p1;
    logic             vld_p1;

    // The output slot can take a new beat whenever it is empty or being drained
    // in this same cycle, so full throughput needs no bubble.
    assign in_ready  = !vld_p1 | out_ready;
    assign accept_p0 = in_valid & in_ready;

    // acc_p1 always reflects the last accepted beat, even if y is still unconsumed.
    assign b_eff_p0 = acc_sel ? acc_p1 : b;

    logic_unit_core #(
        .WIDTH (WIDTH)
    ) u_core (
        .a     (a),
        .b_eff (b_eff_p0),
        .op    (op),
        .r     (r_p0)
    );

    // ---- stage p0 -> p1: output register, flags, accumulator, occupancy ----
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            vld_p1    <= 1'b0;
            y_p1      <= '0;
            zero_p1   <= 1'b1;
            parity_p1 <= 1'b0;
            acc_p1    <= ACC_RST;
        end else if (accept_p0) begin
            vld_p1    <= 1'b1;
            y_p1      <= r_p0;
            zero_p1   <= (r_p0 == '0);
            parity_p1 <= ^r_p0;
            acc_p1    <= r_p0;
        end else if (out_ready) begin
            vld_p1    <= 1'b0;
        end
    end

    assign out_valid = vld_p1;
    assign y         = y_p1;
    assign zero      = zero_p1;
    assign parity    = parity_p1;

endmodule

// File: tb/tb_logic_unit_pipe.sv
module tb_logic_unit_pipe;
    import logic_unit_pkg::*;

    logic       clk;
    logic       reset_n;
    logic       in_valid;
    logic       in_ready;
    logic [2:0] op;
    logic       acc_sel;
    logic [7:0] a;
    logic [7:0] b;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] y;
    logic       zero;
    logic       parity;

    logic       w1_in_valid;
    logic       w1_in_ready;
    logic [2:0] w1_op;
    logic       w1_acc_sel;
    logic [0:0] w1_a;
    logic [0:0] w1_b;
    logic       w1_out_valid;
    logic       w1_out_ready;
    logic [0:0] w1_y;
    logic       w1_zero;
    logic       w1_parity;

    int n_checks;
    int n_errors;

    logic [7:0] ops_exp [8];

    logic_unit_pipe #(.WIDTH(8), .ACC_INIT(0)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .acc_sel   (acc_sel),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .y         (y),
        .zero      (zero),
        .parity    (parity)
    );

    logic_unit_pipe #(.WIDTH(1), .ACC_INIT(0)) dut_w1 (
        .clk       (clk),
        .reset_n   (reset_n),
        .in_valid  (w1_in_valid),
        .in_ready  (w1_in_ready),
        .op        (w1_op),
        .acc_sel   (w1_acc_sel),
        .a         (w1_a),
        .b         (w1_b),
        .out_valid (w1_out_valid),
        .out_ready (w1_out_ready),
        .y         (w1_y),
        .zero      (w1_zero),
        .parity    (w1_parity)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Present a beat, let one edge pass, leave the bench 1 time unit after it.
    task automatic beat(input logic [2:0] o, input logic s, input logic [7:0] va, input logic [7:0] vb);
        in_valid = 1'b1;
        op       = o;
        acc_sel  = s;
        a        = va;
        b        = vb;
        @(posedge clk);
        #1;
    endtask

    task automatic w1_beat(input logic [2:0] o, input logic va, input logic vb);
        w1_in_valid = 1'b1;
        w1_op       = o;
        w1_acc_sel  = 1'b0;
        w1_a        = va;
        w1_b        = vb;
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        ops_exp[0] = 8'h30; ops_exp[1] = 8'hFC; ops_exp[2] = 8'hCC; ops_exp[3] = 8'hCF;
        ops_exp[4] = 8'h03; ops_exp[5] = 8'h33; ops_exp[6] = 8'h0F; ops_exp[7] = 8'hF0;

        reset_n   = 1'b0;
        in_valid  = 1'b0;
        op        = OP_AND;
        acc_sel   = 1'b0;
        a         = '0;
        b         = '0;
        out_ready = 1'b1;
        w1_in_valid  = 1'b0;
        w1_op        = OP_AND;
        w1_acc_sel   = 1'b0;
        w1_a         = '0;
        w1_b         = '0;
        w1_out_ready = 1'b1;

        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_y", 32'(y), 32'h00);
        check("rst_zero", 32'(zero), 32'd1);
        check("rst_parity", 32'(parity), 32'd0);
        check("rst_w1_zero", 32'(w1_zero), 32'd1);
        reset_n = 1'b1;
        @(posedge clk);
        #1;

        // All eight opcodes, a=F0 b=3C, consumer always ready
        for (int i = 0; i < 8; i++) begin
            beat(3'(i), 1'b0, 8'hF0, 8'h3C);
            check($sformatf("op%0d_y", i), 32'(y), 32'(ops_exp[i]));
            check($sformatf("op%0d_valid", i), 32'(out_valid), 32'd1);
            check($sformatf("op%0d_zero", i), 32'(zero), 32'd0);
            check($sformatf("op%0d_parity", i), 32'(parity), 32'd0);
        end

        // Backpressure: hold result for two edges, then drain+accept in one edge
        beat(OP_AND, 1'b0, 8'hF0, 8'h3C);
        check("bp_first_y", 32'(y), 32'h30);
        out_ready = 1'b0;
        op        = OP_OR;
        #1;
        check("bp_in_ready_low", 32'(in_ready), 32'd0);
        for (int i = 0; i < 2; i++) begin
            @(posedge clk);
            #1;
            check($sformatf("bp_hold%0d_y", i), 32'(y), 32'h30);
            check($sformatf("bp_hold%0d_valid", i), 32'(out_valid), 32'd1);
        end
        out_ready = 1'b1;
        #1;
        check("bp_in_ready_high", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        check("bp_replace_y", 32'(y), 32'hFC);
        check("bp_replace_valid", 32'(out_valid), 32'd1);
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        check("drain_valid", 32'(out_valid), 32'd0);
        check("drain_y_hold", 32'(y), 32'hFC);

        // Asynchronous reset while a result sits stalled
        beat(OP_BUF, 1'b0, 8'h80, 8'h00);
        in_valid  = 1'b0;
        out_ready = 1'b0;
        @(posedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        check("async_rst_valid", 32'(out_valid), 32'd0);
        check("async_rst_y", 32'(y), 32'h00);
        check("async_rst_zero", 32'(zero), 32'd1);
        check("async_rst_parity", 32'(parity), 32'd0);
        @(posedge clk);
        #1;
        reset_n   = 1'b1;
        out_ready = 1'b1;
        @(posedge clk);
        #1;

        // Accumulate chain from ACC_INIT=0; b is deliberately garbage
        beat(OP_XOR, 1'b1, 8'h01, 8'hFF);
        check("acc_xor1", 32'(y), 32'h01);
        beat(OP_XOR, 1'b1, 8'h02, 8'hFF);
        check("acc_xor2", 32'(y), 32'h03);
        beat(OP_XOR, 1'b1, 8'h04, 8'hFF);
        check("acc_xor3", 32'(y), 32'h07);
        beat(OP_AND, 1'b1, 8'h05, 8'h00);
        check("acc_and", 32'(y), 32'h05);

        // Sixteen back-to-back beats
        for (int i = 0; i < 16; i++) begin
            beat(OP_BUF, 1'b0, 8'(i * 7 + 1), 8'h00);
            check($sformatf("tp%0d_y", i), 32'(y), 32'(8'(i * 7 + 1)));
            check($sformatf("tp%0d_valid", i), 32'(out_valid), 32'd1);
            check($sformatf("tp%0d_in_ready", i), 32'(in_ready), 32'd1);
        end

        // Flag corners
        beat(OP_BUF, 1'b0, 8'h00, 8'h00);
        check("flag00_zero", 32'(zero), 32'd1);
        check("flag00_parity", 32'(parity), 32'd0);
        beat(OP_BUF, 1'b0, 8'h80, 8'h00);
        check("flag80_zero", 32'(zero), 32'd0);
        check("flag80_parity", 32'(parity), 32'd1);
        in_valid = 1'b0;

        // WIDTH=1 build
        w1_beat(OP_BUF, 1'b1, 1'b0);
        check("w1_buf_y", 32'(w1_y), 32'd1);
        check("w1_buf_zero", 32'(w1_zero), 32'd0);
        check("w1_buf_parity", 32'(w1_parity), 32'd1);
        check("w1_buf_valid", 32'(w1_out_valid), 32'd1);
        w1_beat(OP_XOR, 1'b1, 1'b1);
        check("w1_xor_y", 32'(w1_y), 32'd0);
        check("w1_xor_zero", 32'(w1_zero), 32'd1);
        check("w1_xor_parity", 32'(w1_parity), 32'd0);
        w1_beat(OP_INV, 1'b0, 1'b0);
        check("w1_inv_y", 32'(w1_y), 32'd1);
        w1_in_valid = 1'b0;
        @(posedge clk);
        #1;
        check("w1_drain_valid", 32'(w1_out_valid), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
